alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
- Shares one 4-bit add/sub datapath between two requesters: the mux-selected B operand feeding a ripple or CLA adder, with result {cout, d[3:0]}.
- Arbitrates round-robin and drives the datapath operands, holding them stable while the gate-delayed adder settles.
- Captures the 5-bit result after a programmable number of clock cycles and returns it to the granted requester over a valid/ready handshake.
- Sits between requester logic and the purely combinational gate-level datapath.

Parameters:
- WIDTH, 4: operand width; result is WIDTH+1 bits.
- SETTLE_CYCLES, 3: clock cycles operands are held before capture; legal range >=1. Must cover worst-case datapath delay: ripple path needs >=70 ns, CLA path >=55 ns.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept.
- req_a  in  2*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B, packed the same way.
- req_op  in  6  op per requester; bits [i*3 +: 3] = {s[1:0], cin}.
- rsp_valid  out  2  per-requester result valid.
- rsp_ready  in  2  per-requester result accept.
- rsp_data  out  WIDTH+1  {cout, d}; shared by both requesters, qualified by rsp_valid.
- alu_a  out  WIDTH  to datapath a.
- alu_b  out  WIDTH  to datapath b.
- alu_s  out  2  to datapath mux select.
- alu_cin  out  1  to datapath cin.
- alu_d  in  WIDTH  datapath sum.
- alu_cout  in  1  datapath carry out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, async on rst_n low:
  - State IDLE; settle counter 0; last_grant = 1, so requester 0 wins first.
  - All outputs 0: alu_*, rsp_data, rsp_valid, busy. req_ready is 0 while reset is asserted.
- States:
  - IDLE: grant = combinational round-robin over req_valid; the requester not equal to last_grant has priority. req_ready[g] = (state==IDLE) & req_valid[g]; at most one bit is set.
    - On handshake: latch a, b and op of g into alu_a, alu_b and {alu_s, alu_cin}; record g; counter = SETTLE_CYCLES-1; go to SETTLE.
    - No valid: stay in IDLE. alu_* hold their previous values and are never toggled.
  - SETTLE: alu_* held constant. Counter decrements each cycle. When counter==0, register {alu_cout, alu_d} into rsp_data and go to RESP.
  - RESP: rsp_valid[g]=1 and rsp_data held stable. On rsp_ready[g], last_grant = g and go to IDLE. Otherwise hold indefinitely, with no new grants.
- Latency and throughput:
  - Handshake in cycle 0 -> SETTLE in cycles 1..SETTLE_CYCLES -> rsp_valid from cycle SETTLE_CYCLES+1.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles.
- Op semantics (datapath result, 5-bit, modulo 32):
  - 000 a+b
  - 001 a+b+1
  - 010 a+~b
  - 011 a-b (a+~b+1)
  - 100 a
  - 101 a+1
  - 110 a-1 (a+1111)
  - 111 a+1111+1
  - The scheduler does not compute these; it only sequences and captures.
- Handshake rules:
  - req_ready may depend on req_valid.
  - Requesters must keep valid and operands stable until ready.
  - rsp_valid is never dropped without rsp_ready.
- Boundary conditions:
  - Simultaneous requests: the non-last_grant requester wins. The loser's valid stays pending and is granted next.
  - The same requester re-requesting with no competitor is granted again.
  - rsp_ready on the non-granted index is ignored.
  - rst_n asserted in SETTLE or RESP aborts the operation with no response; the aborted request is not replayed.
  - Counter is sized to clog2(SETTLE_CYCLES)+1 bits; SETTLE_CYCLES=1 means capture after exactly one held cycle.

Decomposition:
- Shared defines file alu_sched_defs:
  - Op encodings OP_ADD=000, OP_ADD1=001, OP_ADDN=010, OP_SUB=011, OP_PASS=100, OP_INC=101, OP_DEC=110, OP_PASSC=111.
  - State encodings IDLE=2'b00, SETTLE=2'b01, RESP=2'b10.
- One sub-module, rr_arbiter2: inputs req[1:0] and last[0]; output one-hot grant[1:0]; purely combinational.

Test Plan (SETTLE_CYCLES=3, datapath = CLA system model, clk period 60 ns):
- Reset release; req0 a=0101 b=0011 op=000 -> req_ready[0] 1 cycle; alu_*=0101/0011/00/0 stable 3 cycles; rsp_valid[0] in cycle 4 with rsp_data=01000.
- req1 a=0011 b=0101 op=011 -> rsp_data=01110 on rsp_valid[1]. Then a=0000 op=110 -> 01111. Then a=0101 op=111 -> 10101.
- req0 and req1 valid together after reset -> req0 served first, then req1 with no idle gap beyond one IDLE cycle; third round with both valid -> req0 again (alternation).
- rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_data held, busy=1, req_ready=00 despite pending req1; after ready, req1 granted next cycle.
- rst_n low in cycle 2 of SETTLE -> all outputs 0 immediately (async); after release, no rsp_valid appears for the aborted op; a new req1 is granted first only if req0 is idle.

Source files
------------

// File: rtl/alu_req_scheduler_pkg.sv
// Shared encodings for the ALU request scheduler: datapath op codes and
// controller states.
package alu_req_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Op field is {s[1:0], cin} as presented to the gate-level datapath.
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADD1  = 3'b001;
  localparam logic [2:0] OP_ADDN  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_PASS  = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_PASSC = 3'b111;

endpackage

// File: rtl/alu_req_scheduler_arb.sv
// Two-way round-robin arbiter: on contention the requester that was not
// served last wins; grant is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    else              grant = req;
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Time-shares one combinational add/sub datapath between two requesters:
// grant, hold operands for SETTLE_CYCLES, capture {cout, d}, return result.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH:0]     rsp_data,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_s,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_d,
  input  logic               alu_cout,
  output logic               busy
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_grant;
  logic            gsel;
  logic [1:0]      grant;
  logic            gidx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]      sel_op;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // rst_n gates req_ready so no handshake is offered while held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE) req_ready = grant;
    gidx   = grant[1];
    sel_a  = gidx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    sel_b  = gidx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    sel_op = gidx ? req_op[5:3] : req_op[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gsel       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      alu_cin    <= 1'b0;
      rsp_data   <= '0;
      rsp_valid  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_s   <= sel_op[2:1];
            alu_cin <= sel_op[0];
            gsel    <= gidx;
            cnt     <= CW'(SETTLE_CYCLES - 1);
            state   <= SETTLE;
            busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_data  <= {alu_cout, alu_d};
            rsp_valid <= gsel ? 2'b10 : 2'b01;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[gsel]) begin
            rsp_valid  <= '0;
            last_grant <= gsel;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a behavioural datapath model
// and hand-computed expected results.
module tb_alu_req_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [5:0] req_op;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [4:0] rsp_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_s;
  logic       alu_cin;
  logic [3:0] alu_d;
  logic       alu_cout;
  logic       busy;

  int tests;
  int fails;

  alu_req_scheduler #(.WIDTH(4), .SETTLE_CYCLES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_cin   (alu_cin),
    .alu_d     (alu_d),
    .alu_cout  (alu_cout),
    .busy      (busy)
  );

  // Datapath model: B mux (b, ~b, 0000, 1111) into a 4-bit adder with carry.
  logic [3:0] bm;
  logic [4:0] sum5;
  always_comb begin
    case (alu_s)
      2'b00:   bm = alu_b;
      2'b01:   bm = ~alu_b;
      2'b10:   bm = 4'b0000;
      default: bm = 4'b1111;
    endcase
    sum5     = {1'b0, alu_a} + {1'b0, bm} + {4'b0000, alu_cin};
    alu_d    = sum5[3:0];
    alu_cout = sum5[4];
  end

  initial clk = 1'b0;
  always #30 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [4:0] exp;
    int         hold;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [4:0] exp, input int hold);
    logic [1:0] want;
    want = (idx == 0) ? 2'b01 : 2'b10;
    req_a[idx*4 +: 4]  = a;
    req_b[idx*4 +: 4]  = b;
    req_op[idx*3 +: 3] = op;
    req_valid[idx]     = 1'b1;
    #1;
    chk("grant", 8'(req_ready), 8'(want));
    tick();
    req_valid[idx] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("settle_a", 8'(alu_a), 8'(a));
      chk("settle_b", 8'(alu_b), 8'(b));
      chk("settle_op", 8'({alu_s, alu_cin}), 8'(op));
      chk("settle_busy", 8'(busy), 8'd1);
      chk("settle_rsp_valid", 8'(rsp_valid), 8'd0);
      chk("settle_req_ready", 8'(req_ready), 8'd0);
      tick();
    end
    chk("rsp_valid", 8'(rsp_valid), 8'(want));
    chk("rsp_data", 8'(rsp_data), 8'(exp));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~want;
      tick();
      chk("hold_rsp_valid", 8'(rsp_valid), 8'(want));
      chk("hold_rsp_data", 8'(rsp_data), 8'(exp));
      chk("hold_busy", 8'(busy), 8'd1);
      chk("hold_req_ready", 8'(req_ready), 8'd0);
    end
    rsp_ready = want;
    tick();
    rsp_ready = 2'b00;
    chk("done_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("done_busy", 8'(busy), 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{0, 4'b0101, 4'b0011, 3'b000, 5'b01000, 0};
    vecs[1] = '{1, 4'b0011, 4'b0101, 3'b011, 5'b01110, 2};
    vecs[2] = '{1, 4'b0000, 4'b0000, 3'b110, 5'b01111, 0};
    vecs[3] = '{1, 4'b0101, 4'b0000, 3'b111, 5'b10101, 1};
    vecs[4] = '{0, 4'b1111, 4'b0001, 3'b001, 5'b10001, 0};
    vecs[5] = '{0, 4'b1010, 4'b0011, 3'b010, 5'b10110, 0};
    vecs[6] = '{1, 4'b1001, 4'b0110, 3'b100, 5'b01001, 0};
    vecs[7] = '{0, 4'b1111, 4'b0000, 3'b101, 5'b10000, 0};
    vecs[8] = '{1, 4'b0000, 4'b1111, 3'b000, 5'b01111, 0};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b00;
    tick();
    chk("rst_req_ready", 8'(req_ready), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp_data", 8'(rsp_data), 8'd0);
    chk("rst_alu", 8'({alu_a, alu_b}), 8'd0);
    chk("rst_alu_op", 8'({alu_s, alu_cin}), 8'd0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_alu_hold", 8'({alu_a, alu_b}), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].hold);

    // Contention after reset: req0 first, pending req1 next, then req0 again.
    do_reset();
    req_a[7:4]  = 4'b0110;
    req_b[7:4]  = 4'b0010;
    req_op[5:3] = 3'b000;
    req_valid[1] = 1'b1;
    do_op(0, 4'b0001, 4'b0001, 3'b000, 5'b00010, 5);
    do_op(1, 4'b0110, 4'b0010, 3'b000, 5'b01000, 0);
    req_a[7:4]  = 4'b0111;
    req_b[7:4]  = 4'b0111;
    req_op[5:3] = 3'b011;
    req_valid[1] = 1'b1;
    do_op(0, 4'b1000, 4'b1000, 3'b000, 5'b10000, 0);
    do_op(1, 4'b0111, 4'b0111, 3'b011, 5'b10000, 0);

    // Reset during SETTLE aborts without a response.
    req_a[3:0]  = 4'b0110;
    req_b[3:0]  = 4'b0001;
    req_op[2:0] = 3'b000;
    req_valid[0] = 1'b1;
    #1;
    chk("abort_grant", 8'(req_ready), 8'd1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    req_valid[1] = 1'b1;
    #5;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_alu", 8'({alu_a, alu_b}), 8'd0);
    chk("abort_alu_op", 8'({alu_s, alu_cin}), 8'd0);
    chk("abort_rsp_data", 8'(rsp_data), 8'd0);
    chk("abort_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("abort_req_ready", 8'(req_ready), 8'd0);
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_abort_rsp_valid", 8'(rsp_valid), 8'd0);
      chk("post_abort_busy", 8'(busy), 8'd0);
    end
    do_op(1, 4'b0011, 4'b0100, 3'b010, 5'b01110, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
